// File: rtl/ocimem_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, grant identities, debug ROM region tag.
package ocimem_pkg;
   typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAPT, RESP} state_t;
   typedef enum logic {GNT_JTAG, GNT_AV} grant_t;
   localparam logic [1:0] ROM_REGION = 2'b11;
endpackage

// File: rtl/nios2pio_qsys_nios2_gen2_0_cpu_ocimem_jtag_latch.sv
// One-deep holding register for pulsed JTAG commands; a pulse while full is dropped and flagged sticky.
// Loads on the pulse cycle, visible the next cycle; cleared when the arbiter takes it.
module nios2pio_qsys_nios2_gen2_0_cpu_ocimem_jtag_latch
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              take,
   output logic              pending,
   output logic              pend_wr,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [DATA_W-1:0] pend_wdata,
   output logic              overrun
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending    <= 1'b0;
         pend_wr    <= 1'b0;
         pend_addr  <= '0;
         pend_wdata <= '0;
         overrun    <= 1'b0;
      end else begin
         if (take)
            pending <= 1'b0;
         // A pulse arriving while full is lost even if the slot frees this cycle.
         if (rd || wr) begin
            if (pending) begin
               overrun <= 1'b1;
            end else begin
               pending    <= 1'b1;
               pend_wr    <= wr;
               pend_addr  <= addr;
               pend_wdata <= wdata;
            end
         end
      end
   end

endmodule

// File: rtl/nios2pio_qsys_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Round-robin arbiter of the OCI RAM between latched JTAG commands and the Avalon debug slave.
// Write done in cycle 1, read in cycle 3; Avalon stalls via waitrequest. OCIMEM_ROM_PROTECT_EN blocks Avalon writes to the top quarter.
module nios2pio_qsys_nios2_gen2_0_cpu_ocimem_arbiter
   import ocimem_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  jtag_rd,
   input  logic                  jtag_wr,
   input  logic [ADDR_W-1:0]     jtag_addr,
   input  logic [DATA_W-1:0]     jtag_wdata,
   output logic [DATA_W-1:0]     jtag_rdata,
   output logic                  jtag_done,
   output logic                  jtag_overrun,
   input  logic                  av_read,
   input  logic                  av_write,
   input  logic [ADDR_W-1:0]     av_address,
   input  logic [DATA_W-1:0]     av_writedata,
   input  logic [DATA_W/8-1:0]   av_byteenable,
   input  logic                  av_debugaccess,
   output logic [DATA_W-1:0]     av_readdata,
   output logic                  av_waitrequest,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   output logic [DATA_W/8-1:0]   ram_be,
   output logic                  ram_we,
   input  logic [DATA_W-1:0]     ram_rdata
);

   state_t              state;
   grant_t              owner, last_grant, gnt;
   logic                jp_pending, jp_wr, jp_take;
   logic [ADDR_W-1:0]   jp_addr;
   logic [DATA_W-1:0]   jp_wdata;
   logic                av_req, av_wr_ok, rom_hit;

   nios2pio_qsys_nios2_gen2_0_cpu_ocimem_jtag_latch #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_jtag_latch (
      .clk        (clk),
      .reset      (reset),
      .rd         (jtag_rd),
      .wr         (jtag_wr),
      .addr       (jtag_addr),
      .wdata      (jtag_wdata),
      .take       (jp_take),
      .pending    (jp_pending),
      .pend_wr    (jp_wr),
      .pend_addr  (jp_addr),
      .pend_wdata (jp_wdata),
      .overrun    (jtag_overrun)
   );

   assign av_req = av_read | av_write;

`ifdef OCIMEM_ROM_PROTECT_EN
   assign rom_hit = (av_address[ADDR_W-1 -: 2] == ROM_REGION);
`else
   assign rom_hit = 1'b0;
`endif

   assign av_wr_ok = av_debugaccess && !rom_hit;

   always_comb begin
      gnt = GNT_AV;
      if (jp_pending && (!av_req || last_grant == GNT_AV))
         gnt = GNT_JTAG;
   end

   assign jp_take = (state == IDLE) && jp_pending && (gnt == GNT_JTAG);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         owner          <= GNT_JTAG;
         last_grant     <= GNT_JTAG;
         ram_addr       <= '0;
         ram_wdata      <= '0;
         ram_be         <= '0;
         ram_we         <= 1'b0;
         av_waitrequest <= 1'b1;
         av_readdata    <= '0;
         jtag_rdata     <= '0;
         jtag_done      <= 1'b0;
      end else begin
         ram_we         <= 1'b0;
         jtag_done      <= 1'b0;
         av_waitrequest <= 1'b1;
         case (state)
            IDLE: begin
               if (jp_take) begin
                  owner      <= GNT_JTAG;
                  last_grant <= GNT_JTAG;
                  ram_addr   <= jp_addr;
                  ram_wdata  <= jp_wdata;
                  ram_be     <= '1;
                  if (jp_wr) begin
                     ram_we    <= 1'b1;
                     jtag_done <= 1'b1;
                     state     <= WR;
                  end else begin
                     state <= RD_ISSUE;
                  end
               end else if (av_req) begin
                  owner      <= GNT_AV;
                  last_grant <= GNT_AV;
                  ram_addr   <= av_address;
                  ram_wdata  <= av_writedata;
                  ram_be     <= av_byteenable;
                  // Rejected writes still complete on the bus so the master never hangs.
                  if (av_write) begin
                     ram_we         <= av_wr_ok;
                     av_waitrequest <= 1'b0;
                     state          <= WR;
                  end else begin
                     state <= RD_ISSUE;
                  end
               end
            end
            WR:       state <= IDLE;
            RD_ISSUE: state <= RD_CAPT;
            RD_CAPT: begin
               if (owner == GNT_AV) begin
                  av_readdata    <= ram_rdata;
                  av_waitrequest <= 1'b0;
               end else begin
                  jtag_rdata <= ram_rdata;
                  jtag_done  <= 1'b1;
               end
               state <= RESP;
            end
            RESP:     state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2pio_qsys_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a 1-cycle-latency RAM model.
module tb_nios2pio_qsys_nios2_gen2_0_cpu_ocimem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        jtag_rd = 1'b0, jtag_wr = 1'b0;
   logic [7:0]  jtag_addr = '0;
   logic [31:0] jtag_wdata = '0;
   logic [31:0] jtag_rdata;
   logic        jtag_done, jtag_overrun;
   logic        av_read = 1'b0, av_write = 1'b0;
   logic [7:0]  av_address = '0;
   logic [31:0] av_writedata = '0;
   logic [3:0]  av_byteenable = '0;
   logic        av_debugaccess = 1'b0;
   logic [31:0] av_readdata;
   logic        av_waitrequest;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic        ram_we;
   logic [31:0] ram_rdata = '0;

   logic [31:0] mem [0:255];
   logic        mem_clear = 1'b1;
   int          wr_count = 0;
   int          checks = 0;
   int          failures = 0;

   nios2pio_qsys_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .jtag_rd        (jtag_rd),
      .jtag_wr        (jtag_wr),
      .jtag_addr      (jtag_addr),
      .jtag_wdata     (jtag_wdata),
      .jtag_rdata     (jtag_rdata),
      .jtag_done      (jtag_done),
      .jtag_overrun   (jtag_overrun),
      .av_read        (av_read),
      .av_write       (av_write),
      .av_address     (av_address),
      .av_writedata   (av_writedata),
      .av_byteenable  (av_byteenable),
      .av_debugaccess (av_debugaccess),
      .av_readdata    (av_readdata),
      .av_waitrequest (av_waitrequest),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_be         (ram_be),
      .ram_we         (ram_we),
      .ram_rdata      (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
      end else if (ram_we) begin
         wr_count <= wr_count + 1;
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int w0;
      bit ack_seen;
      reset = 1'b1;
      tick(); tick();
      checks++;
      if (av_waitrequest !== 1'b1 || ram_we !== 1'b0 || jtag_done !== 1'b0 || jtag_overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: wait=%b we=%b done=%b ovr=%b, required 1 0 0 0", av_waitrequest, ram_we, jtag_done, jtag_overrun);
      end
      checks++;
      if (ram_addr !== 8'h0 || av_readdata !== 32'h0 || jtag_rdata !== 32'h0 || ram_be !== 4'h0) begin
         failures++;
         $display("FAIL reset_data: addr=%h avrd=%h jrd=%h be=%h, required all 0", ram_addr, av_readdata, jtag_rdata, ram_be);
      end
      mem_clear = 1'b0;
      reset = 1'b0;
      tick();
      // Avalon read wins; JTAG write is left pending, then reset hits during RD_CAPT
      av_read = 1'b1; av_address = 8'h10;
      jtag_wr = 1'b1; jtag_addr = 8'h60; jtag_wdata = 32'h5555AAAA;
      tick();
      jtag_wr = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (av_waitrequest !== 1'b1 || ram_we !== 1'b0 || jtag_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_capt: wait=%b we=%b done=%b, required 1 0 0", av_waitrequest, ram_we, jtag_done);
      end
      tick();
      reset = 1'b0;
      av_read = 1'b0;
      w0 = wr_count;
      ack_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (av_waitrequest !== 1'b1 || jtag_done !== 1'b0) ack_seen = 1'b1;
      end
      checks++;
      if (ack_seen || wr_count != w0) begin
         failures++;
         $display("FAIL reset_abort: ack_seen=%0b writes=%0d, required 0 0", ack_seen, wr_count - w0);
      end
   endtask

   task automatic test_av_read();
      av_read = 1'b1; av_address = 8'h10;
      #1;
      checks++;
      if (av_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL av_read_c0: wait=%b required 1", av_waitrequest);
      end
      tick(); tick();
      checks++;
      if (av_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL av_read_c2: wait=%b required 1", av_waitrequest);
      end
      tick();
      checks++;
      if (av_waitrequest !== 1'b0 || av_readdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL av_read_c3: wait=%b data=%h, required 0 deadbeef", av_waitrequest, av_readdata);
      end
      av_read = 1'b0;
      tick();
   endtask

   task automatic test_jtag_write_read();
      jtag_wr = 1'b1; jtag_addr = 8'h20; jtag_wdata = 32'h12345678;
      tick();
      jtag_wr = 1'b0;
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 8'h20 || ram_be !== 4'hF || ram_wdata !== 32'h12345678 || jtag_done !== 1'b1) begin
         failures++;
         $display("FAIL jtag_wr: we=%b addr=%h be=%h wd=%h done=%b, required 1 20 f 12345678 1",
                  ram_we, ram_addr, ram_be, ram_wdata, jtag_done);
      end
      tick();
      checks++;
      if (ram_we !== 1'b0 || jtag_done !== 1'b0) begin
         failures++;
         $display("FAIL jtag_wr_pulse: we=%b done=%b, required 0 0", ram_we, jtag_done);
      end
      jtag_rd = 1'b1; jtag_addr = 8'h20;
      tick();
      jtag_rd = 1'b0;
      tick(); tick();
      checks++;
      if (jtag_done !== 1'b0) begin
         failures++;
         $display("FAIL jtag_rd_early: done=%b required 0", jtag_done);
      end
      tick();
      checks++;
      if (jtag_done !== 1'b1 || jtag_rdata !== 32'h12345678 || av_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL jtag_readback: done=%b data=%h wait=%b, required 1 12345678 1", jtag_done, jtag_rdata, av_waitrequest);
      end
      tick();
   endtask

   task automatic test_same_cycle();
      int n;
      av_read = 1'b1; av_address = 8'h20;
      jtag_rd = 1'b1; jtag_addr = 8'h10;
      tick();
      jtag_rd = 1'b0;
      tick(); tick();
      checks++;
      if (av_waitrequest !== 1'b0 || av_readdata !== 32'h12345678 || jtag_done !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_av: wait=%b data=%h done=%b, required 0 12345678 0", av_waitrequest, av_readdata, jtag_done);
      end
      av_read = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         n++;
         if (jtag_done) break;
      end
      checks++;
      if (n != 4 || jtag_done !== 1'b1 || jtag_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL same_cycle_jtag: cycles=%0d done=%b data=%h, required 4 1 deadbeef", n, jtag_done, jtag_rdata);
      end
      tick();
   endtask

   task automatic test_av_write_be();
      av_write = 1'b1; av_address = 8'h40; av_writedata = 32'hAABBCCDD;
      av_byteenable = 4'h5; av_debugaccess = 1'b1;
      tick();
      checks++;
      if (av_waitrequest !== 1'b0 || ram_we !== 1'b1 || ram_be !== 4'h5 || ram_addr !== 8'h40) begin
         failures++;
         $display("FAIL av_write: wait=%b we=%b be=%h addr=%h, required 0 1 5 40", av_waitrequest, ram_we, ram_be, ram_addr);
      end
      av_write = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      jtag_wr = 1'b1; jtag_addr = 8'h30; jtag_wdata = 32'hA5A5A5A5;
      tick();
      jtag_wr = 1'b0;
      av_read = 1'b1; av_address = 8'h40;
      tick();
      checks++;
      if (jtag_done !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h30 || av_waitrequest !== 1'b1) begin
         failures++;
         $display("FAIL rr_jtag_first: done=%b we=%b addr=%h wait=%b, required 1 1 30 1", jtag_done, ram_we, ram_addr, av_waitrequest);
      end
      tick(); tick(); tick(); tick();
      checks++;
      if (av_waitrequest !== 1'b0 || av_readdata !== 32'h00BB00DD) begin
         failures++;
         $display("FAIL rr_av_second: wait=%b data=%h, required 0 00bb00dd", av_waitrequest, av_readdata);
      end
      av_read = 1'b0;
      tick();
   endtask

   task automatic test_overrun();
      int w0;
      w0 = wr_count;
      jtag_wr = 1'b1; jtag_addr = 8'h50; jtag_wdata = 32'h11111111;
      tick();
      jtag_addr = 8'h54; jtag_wdata = 32'h22222222;
      tick();
      jtag_wr = 1'b0;
      checks++;
      if (jtag_overrun !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 8'h50 || ram_wdata !== 32'h11111111) begin
         failures++;
         $display("FAIL overrun_first: ovr=%b we=%b addr=%h wd=%h, required 1 1 50 11111111", jtag_overrun, ram_we, ram_addr, ram_wdata);
      end
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (jtag_overrun !== 1'b1 || wr_count - w0 != 1 || mem[8'h54] !== 32'h0) begin
         failures++;
         $display("FAIL overrun_sticky: ovr=%b writes=%0d m54=%h, required 1 1 0", jtag_overrun, wr_count - w0, mem[8'h54]);
      end
   endtask

   task automatic test_protect();
      logic exp_we;
`ifdef OCIMEM_ROM_PROTECT_EN
      exp_we = 1'b0;
`else
      exp_we = 1'b1;
`endif
      av_write = 1'b1; av_address = 8'hC4; av_writedata = 32'hCAFEF00D;
      av_byteenable = 4'hF; av_debugaccess = 1'b1;
      tick();
      checks++;
      if (av_waitrequest !== 1'b0 || ram_we !== exp_we) begin
         failures++;
         $display("FAIL rom_write: wait=%b we=%b, required 0 %b", av_waitrequest, ram_we, exp_we);
      end
      av_write = 1'b0;
      tick();
      av_write = 1'b1; av_address = 8'h44; av_debugaccess = 1'b0;
      tick();
      checks++;
      if (av_waitrequest !== 1'b0 || ram_we !== 1'b0) begin
         failures++;
         $display("FAIL no_debugaccess: wait=%b we=%b, required 0 0", av_waitrequest, ram_we);
      end
      av_write = 1'b0;
      tick();
      checks++;
      if (mem[8'h44] !== 32'h0) begin
         failures++;
         $display("FAIL no_debugaccess_mem: m44=%h required 0", mem[8'h44]);
      end
      jtag_wr = 1'b1; jtag_addr = 8'hC8; jtag_wdata = 32'h0BADF00D;
      tick();
      jtag_wr = 1'b0;
      tick();
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 8'hC8 || jtag_done !== 1'b1) begin
         failures++;
         $display("FAIL jtag_rom_write: we=%b addr=%h done=%b, required 1 c8 1", ram_we, ram_addr, jtag_done);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_av_read();
      test_jtag_write_read();
      test_same_cycle();
      test_av_write_be();
      test_round_robin();
      test_overrun();
      test_protect();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
